// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST session controller slice.
// Holds the session state encoding and the CUT latency limits.
package lbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        COMPARE,
        DONE
    } state_e;

    localparam int CUT_LAT_MAX = 15;
    localparam int DRAIN_BITS  = $clog2(CUT_LAT_MAX + 1);

    function automatic logic is_busy(input state_e s);
        return (s == CLEAR) || (s == RUN) || (s == DRAIN) || (s == COMPARE);
    endfunction

endpackage

// File: rtl/bist_session_ctrl_if.sv
// Bus between the test access logic / TPG-CUT-ORA chain and the session controller.
// The slave modport is the controller; the master modport is everything around it.
interface bist_session_ctrl_if #(
    parameter int PAT_BITS = 16,
    parameter int SIG_BITS = 32
);
    logic                start;
    logic                abort;
    logic [PAT_BITS-1:0] num_patterns;
    logic [SIG_BITS-1:0] golden;
    logic [SIG_BITS-1:0] ora_count;
    logic                ora_rst;
    logic                ora_en;
    logic                tpg_en;
    logic [PAT_BITS-1:0] pat_idx;
    logic                busy;
    logic                done;
    logic                pass;

    modport master (
        output start, abort, num_patterns, golden, ora_count,
        input  ora_rst, ora_en, tpg_en, pat_idx, busy, done, pass
    );

    modport slave (
        input  start, abort, num_patterns, golden, ora_count,
        output ora_rst, ora_en, tpg_en, pat_idx, busy, done, pass
    );
endinterface

// File: rtl/bist_delay_line.sv
// DEPTH-stage 1-bit shift register with synchronous clear.
// Models the CUT pipeline so ora_en lines up with valid CUT responses.
module bist_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/bist_session_ctrl.sv
// LBIST session sequencer: clears the ORA, runs N patterns, drains the CUT
// pipeline, then compares the ORA count against the latched golden value.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// CLEAR   | one cycle, ora_rst high, N/G already latched
// RUN     | N cycles, tpg_en high, pat_idx 0..N-1
// DRAIN   | CUT_LAT cycles, tpg_en low while the pipeline flushes
// COMPARE | one cycle, ora_count sampled against G
// DONE    | result held until the next start
module bist_session_ctrl
    import lbist_pkg::*;
#(
    parameter int PAT_BITS = 16,
    parameter int SIG_BITS = 32,
    parameter int CUT_LAT  = 2
) (
    input logic               clk,
    input logic               rst,
    bist_session_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    logic [PAT_BITS-1:0]   n_q, n_d;
    logic [SIG_BITS-1:0]   g_q, g_d;
    logic [PAT_BITS-1:0]   pat_idx_q, pat_idx_d;
    logic [DRAIN_BITS-1:0] drain_q, drain_d;
    logic                  ora_rst_q, ora_rst_d;
    logic                  tpg_en_q, tpg_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  abort_hit;
    logic                  last_pat;
    logic                  sig_match;
    logic                  ora_en_w;

    assign abort_hit = bus.abort && is_busy(state_q);
    assign last_pat  = (pat_idx_q == (n_q - PAT_BITS'(1)));
    assign sig_match = (bus.ora_count == g_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                if (abort_hit)         state_d = IDLE;
                else if (n_q == '0)    state_d = COMPARE;
                else                   state_d = RUN;
            end
            RUN: begin
                if (abort_hit)         state_d = IDLE;
                else if (last_pat)     state_d = DRAIN;
            end
            DRAIN: begin
                if (abort_hit)         state_d = IDLE;
                else if (drain_q == '0) state_d = COMPARE;
            end
            COMPARE: begin
                if (abort_hit)         state_d = IDLE;
                else                   state_d = DONE;
            end
            DONE: begin
                if (bus.start) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so every port is a flop.
    always_comb begin
        n_d       = n_q;
        g_d       = g_q;
        pat_idx_d = pat_idx_q;
        drain_d   = drain_q;

        if (state_d == CLEAR) begin
            n_d       = bus.num_patterns;
            g_d       = bus.golden;
            pat_idx_d = '0;
        end else if (state_q == RUN && state_d == RUN) begin
            pat_idx_d = pat_idx_q + PAT_BITS'(1);
        end

        if (state_d == DRAIN && state_q != DRAIN) begin
            drain_d = DRAIN_BITS'(CUT_LAT - 1);
        end else if (state_q == DRAIN && drain_q != '0) begin
            drain_d = drain_q - DRAIN_BITS'(1);
        end

        ora_rst_d = (state_d == CLEAR);
        tpg_en_d  = (state_d == RUN);
        busy_d    = is_busy(state_d);
        done_d    = (state_d == DONE);

        if (state_d == DONE) begin
            pass_d = (state_q == COMPARE) ? sig_match : pass_q;
        end else begin
            pass_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            g_q       <= '0;
            pat_idx_q <= '0;
            drain_q   <= '0;
            ora_rst_q <= 1'b0;
            tpg_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            n_q       <= n_d;
            g_q       <= g_d;
            pat_idx_q <= pat_idx_d;
            drain_q   <= drain_d;
            ora_rst_q <= ora_rst_d;
            tpg_en_q  <= tpg_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    // Cleared on abort too, so no stale increments reach the ORA afterwards.
    bist_delay_line #(
        .DEPTH (CUT_LAT)
    ) u_delay_line (
        .clk   (clk),
        .clr_i (rst || abort_hit),
        .d_i   (tpg_en_q),
        .q_o   (ora_en_w)
    );

    assign bus.ora_rst = ora_rst_q;
    assign bus.ora_en  = ora_en_w;
    assign bus.tpg_en  = tpg_en_q;
    assign bus.pat_idx = pat_idx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;

endmodule
